// File: rtl/divider_seq.sv
// Sequential unsigned WIDTH/WIDTH restoring divider, one quotient bit per clock.
// Result is packed {remainder, quotient} so it can share HI/LO capture with the multiplier.
module divider_seq #(
    parameter int           WIDTH     = 32,
    parameter logic [2:0]   DIVU_CODE = 3'b011
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           signal,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic [2*WIDTH-1:0]   dataOut,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic             start;
    logic             last;
    logic [WIDTH-1:0] dvsr, quot, rem;
    logic [CNT_W-1:0] cnt;

    // One restoring step: shift next dividend bit into the partial remainder.
    // The partial remainder can reach 2*dvsr-1, so the compare is one bit wider.
    logic [WIDTH:0]   t;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt, quot_nxt;

    assign t        = {rem, quot[WIDTH-1]};
    assign ge       = t[WIDTH] | (t[WIDTH-1:0] >= dvsr);
    // When ge is set the true difference is < dvsr, so modulo-2^WIDTH is exact.
    assign rem_nxt  = ge ? (t[WIDTH-1:0] - dvsr) : t[WIDTH-1:0];
    assign quot_nxt = {quot[WIDTH-2:0], ge};
    assign last     = (cnt == CNT_W'(WIDTH-1));

    // Status decoded from registered state only: no input-to-output path.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register; reset wins over everything, including mid-operation.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; signal is only honoured in IDLE and on DONE exit.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (signal == DIVU_CODE) begin
                    start     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (signal == DIVU_CODE) begin
                    start     = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands on start, iterate in RUN, publish result on the last step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dvsr        <= '0;
            quot        <= '0;
            rem         <= '0;
            cnt         <= '0;
            dataOut     <= '0;
            div_by_zero <= 1'b0;
        end else if (start) begin
            dvsr <= dataB;
            quot <= dataA;
            rem  <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            rem  <= rem_nxt;
            quot <= quot_nxt;
            cnt  <= cnt + 1'b1;
            if (last) begin
                dataOut     <= {rem_nxt, quot_nxt};
                div_by_zero <= (dvsr == '0);
            end
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Directed and scoreboarded checks for divider_seq.
module tb_divider_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  signal;
    logic [31:0] dataA, dataB;
    logic [63:0] dataOut;
    logic        busy, done, div_by_zero;

    int checks = 0;
    int errors = 0;

    divider_seq dut (
        .clk(clk), .rst(rst), .signal(signal), .dataA(dataA), .dataB(dataB),
        .dataOut(dataOut), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Start a divide with signal pulsed for the E0 edge only, scramble operands
    // afterwards, and wait (bounded) for done. Returns edges-to-done and busy cycles.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output logic dbz,
                           output int lat, output int bcnt, output logic held);
        logic [63:0] prev;
        @(negedge clk);
        signal = 3'b011; dataA = a; dataB = b;
        prev = dataOut;
        @(negedge clk);
        signal = 3'b000; dataA = $urandom; dataB = $urandom;
        lat = 1; bcnt = 0; held = 1'b1;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (dataOut !== prev) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        res = dataOut;
        dbz = div_by_zero;
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res;
        logic        dbz, held, seen;
        int          lat, bcnt, n;
        logic [31:0] a, b;

        // 1: reset with random inputs, including the start code
        rst = 1'b0; signal = 3'b011; dataA = $urandom; dataB = $urandom;
        repeat (2) begin
            @(negedge clk);
            signal = 3'($urandom); dataA = $urandom; dataB = $urandom;
        end
        chk("rst_dataOut", dataOut, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_dbz", {63'h0, div_by_zero}, 64'h0);
        rst = 1'b1; signal = 3'b000;

        // 2: 100/7, latency and busy width
        run_div(32'd100, 32'd7, res, dbz, lat, bcnt, held);
        chk("d100_7", res, 64'h00000002_0000000E);
        chk("d100_7_lat", 64'(lat), 64'd33);
        chk("d100_7_busy", 64'(bcnt), 64'd32);
        chk("d100_7_dbz", {63'h0, dbz}, 64'h0);
        @(negedge clk);
        chk("done_pulse_end", {63'h0, done}, 64'h0);

        // 3: boundaries
        run_div(32'hFFFF_FFFF, 32'd1, res, dbz, lat, bcnt, held);
        chk("dmax_1", res, 64'h00000000_FFFFFFFF);
        chk("held_during_run", {63'h0, held}, 64'h1);
        run_div(32'd3, 32'd10, res, dbz, lat, bcnt, held);
        chk("d3_10", res, 64'h00000003_00000000);
        run_div(32'hFFFF_FFFF, 32'h8000_0000, res, dbz, lat, bcnt, held);
        chk("dmax_msb", res, 64'h7FFFFFFF_00000001);

        // 4: divide by zero, then flag clears on next result
        run_div(32'd5, 32'd0, res, dbz, lat, bcnt, held);
        chk("d5_0", res, 64'h00000005_FFFFFFFF);
        chk("d5_0_dbz", {63'h0, dbz}, 64'h1);
        run_div(32'd20, 32'd4, res, dbz, lat, bcnt, held);
        chk("d20_4", res, 64'h00000000_00000005);
        chk("d20_4_dbz", {63'h0, dbz}, 64'h0);

        // 5: reset mid-run discards the partial result
        @(negedge clk);
        signal = 3'b011; dataA = 32'd100; dataB = 32'd7;
        @(negedge clk);
        signal = 3'b000;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_dataOut", dataOut, 64'h0);
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        chk("midrst_done", {63'h0, done}, 64'h0);
        rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("midrst_no_done", {63'h0, seen}, 64'h0);
        run_div(32'd9, 32'd3, res, dbz, lat, bcnt, held);
        chk("d9_3", res, 64'h00000000_00000003);

        // 6: signal held high, operands changed mid-run, back-to-back starts
        @(negedge clk);
        signal = 3'b011; dataA = 32'd100; dataB = 32'd7;
        @(negedge clk);
        dataA = 32'd50; dataB = 32'd5;
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_lat", 64'(n), 64'd33);
        chk("b2b_first", dataOut, 64'h00000002_0000000E);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        chk("b2b_gap", 64'(n), 64'd33);
        chk("b2b_second", dataOut, 64'h00000000_0000000A);
        signal = 3'b000;
        @(negedge clk);
        chk("b2b_idle_busy", {63'h0, busy}, 64'h0);
        chk("b2b_idle_done", {63'h0, done}, 64'h0);

        // Scoreboard over random pairs, biased toward b=0, b>a, small b and large b
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 5)
                0: b = 32'd0;
                1: begin a = $urandom_range(0, 1000); b = a + 1 + $urandom_range(0, 1000); end
                2: b = $urandom_range(1, 16);
                3: b = b | 32'h8000_0000;
                default: ;
            endcase
            run_div(a, b, res, dbz, lat, bcnt, held);
            chk("rand_res", res, model(a, b));
            chk("rand_dbz", {63'h0, dbz}, {63'h0, (b == 0)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
